// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b, LSB first, one full-subtractor step per tick
// Start/busy/done handshake; the tick is a clock enable from a free-running divider.
module serial_subtractor #(
   parameter int WIDTH = 4,
   parameter int DIV   = 5000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             busy,
   output logic             done
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             br_q, br_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic tick;
   logic d_bit;
   logic bo;
   logic last_step;

   assign tick      = (cnt_q == CNT_LAST);
   assign d_bit     = a_q[0] ^ b_q[0] ^ br_q;
   assign bo        = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
   assign last_step = (state_q == SHIFT) && tick && (bit_q == BIT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         br_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         br_q     <= br_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last_step) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d    = tick ? '0 : cnt_q + 1'b1;
      bit_d    = bit_q;
      br_d     = br_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d    = a;
               b_d    = b;
               br_d   = 1'b0;
               bit_d  = '0;
               busy_d = 1'b1;
            end
         end
         SHIFT: begin
            if (tick) begin
               res_d = {d_bit, res_q[WIDTH-1:1]};
               a_d   = a_q >> 1;
               b_d   = b_q >> 1;
               br_d  = bo;
               bit_d = bit_q + 1'b1;
               // Publish on the same edge that shifts in the final bit.
               if (last_step) begin
                  diff_d   = res_d;
                  borrow_d = bo;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign busy   = busy_q;
   assign done   = done_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - checks DIV=1 and DIV=3 instances against an arithmetic model
module tb_serial_subtractor;
   localparam int W = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic [W-1:0] diff1, diff3;
   logic borrow1, busy1, done1, borrow3, busy3, done3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W), .DIV(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .diff(diff1), .borrow(borrow1), .busy(busy1), .done(done1));

   serial_subtractor #(.WIDTH(W), .DIV(3)) dut3 (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .diff(diff3), .borrow(borrow3), .busy(busy3), .done(done3));

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: clocks since reset, ticks consumed since acceptance, result by plain subtraction.
   int m_div[2] = '{1, 3};
   int m_cnt[2], m_busy[2], m_done[2], m_diff[2], m_borrow[2], m_a[2], m_b[2], m_ticks[2];

   always @(posedge clk or posedge reset) begin : model
      bit tk;
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_cnt[i] = 0; m_busy[i] = 0; m_done[i] = 0;
            m_diff[i] = 0; m_borrow[i] = 0; m_ticks[i] = 0;
         end else begin
            tk = (m_cnt[i] == m_div[i] - 1);
            m_cnt[i] = tk ? 0 : m_cnt[i] + 1;
            m_done[i] = 0;
            if (m_busy[i] == 0) begin
               if (start) begin
                  m_a[i] = int'(a); m_b[i] = int'(b);
                  m_busy[i] = 1; m_ticks[i] = 0;
               end
            end else if (tk) begin
               m_ticks[i]++;
               if (m_ticks[i] == W) begin
                  m_diff[i]   = (m_a[i] - m_b[i]) & ((1 << W) - 1);
                  m_borrow[i] = (m_a[i] < m_b[i]) ? 1 : 0;
                  m_busy[i]   = 0;
                  m_done[i]   = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("d1.diff",   diff1,   m_diff[0]);
      chk("d1.borrow", borrow1, m_borrow[0]);
      chk("d1.busy",   busy1,   m_busy[0]);
      chk("d1.done",   done1,   m_done[0]);
      chk("d3.diff",   diff3,   m_diff[1]);
      chk("d3.borrow", borrow3, m_borrow[1]);
      chk("d3.busy",   busy3,   m_busy[1]);
      chk("d3.done",   done3,   m_done[1]);
   end

   task automatic pulse_start(input int ai, input int bi);
      @(negedge clk);
      start = 1'b1; a = W'(ai); b = W'(bi);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int which, input int limit, output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!((which == 0) ? done1 : done3) && k < limit);
      chk($sformatf("done_seen_dut%0d", which), (which == 0) ? done1 : done3, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   int k, dcount, gap, n_done;
   int d_at[$];
   int vec[3][4] = '{'{3, 9, 10, 1}, '{0, 1, 15, 1}, '{0, 0, 0, 0}};

   initial begin
      repeat (2) @(negedge clk);
      chk("rst.diff", diff1, 0);
      chk("rst.borrow", borrow1, 0);
      chk("rst.busy", busy1, 0);
      chk("rst.done", done1, 0);
      reset = 1'b0;

      // 9-3 with DIV=1: done visible 4 cycles after acceptance
      pulse_start(9, 3);
      chk("t1.busy_after_start", busy1, 1);
      wait_done(0, 50, k);
      chk("t1.latency", k, 4);
      chk("t1.diff", diff1, 6);
      chk("t1.borrow", borrow1, 0);
      chk("t1.busy_at_done", busy1, 0);

      foreach (vec[i]) begin
         pulse_start(vec[i][0], vec[i][1]);
         wait_done(0, 50, k);
         chk($sformatf("t2.diff[%0d]", i), diff1, vec[i][2]);
         chk($sformatf("t2.borrow[%0d]", i), borrow1, vec[i][3]);
      end

      // Second request while busy must be ignored
      pulse_start(12, 5);
      @(negedge clk);
      start = 1'b1; a = 4'd1; b = 4'd1;
      @(negedge clk);
      start = 1'b0;
      dcount = 0;
      repeat (12) begin
         @(negedge clk);
         if (done1) dcount++;
      end
      chk("t3.done_count", dcount, 1);
      chk("t3.diff", diff1, 7);
      chk("t3.borrow", borrow1, 0);

      // Reset mid-operation clears outputs without waiting for a clock
      pulse_start(9, 3);
      repeat (2) @(negedge clk);
      chk("t4.busy_before_reset", busy1, 1);
      #2 reset = 1'b1;
      #1;
      chk("t4.diff_async", diff1, 0);
      chk("t4.borrow_async", borrow1, 0);
      chk("t4.busy_async", busy1, 0);
      chk("t4.done_async", done1, 0);
      @(negedge clk);
      reset = 1'b0;
      pulse_start(5, 5);
      wait_done(0, 50, k);
      chk("t4.diff", diff1, 0);
      chk("t4.borrow", borrow1, 0);

      // DIV=3, accepted mid-period: ticks at 1,4,7,10 clks after acceptance
      do_reset();
      repeat (3) @(negedge clk);
      pulse_start(13, 6);
      wait_done(1, 60, k);
      chk("t5.latency_mid", k, 10);
      chk("t5.diff", diff3, 7);
      chk("t5.borrow", borrow3, 0);

      // DIV=3, acceptance coincides with a tick that must not be consumed
      do_reset();
      repeat (1) @(negedge clk);
      pulse_start(2, 7);
      wait_done(1, 60, k);
      chk("t5.latency_coincident", k, 12);
      chk("t5.diff2", diff3, 11);
      chk("t5.borrow2", borrow3, 1);

      // Held start: back-to-back operations with a single idle cycle between
      @(negedge clk);
      start = 1'b1; a = 4'd8; b = 4'd1;
      gap = 0; n_done = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done1) begin
            n_done++;
            d_at.push_back(i);
            chk("t6.diff", diff1, 7);
         end
         if (n_done == 1 && !busy1) gap++;
      end
      start = 1'b0;
      chk("t6.done_count_ge2", (d_at.size() >= 2) ? 1 : 0, 1);
      if (d_at.size() >= 2) chk("t6.done_spacing", d_at[1] - d_at[0], W + 1);
      chk("t6.busy_gap", gap, 1);
      repeat (10) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
